// File: rtl/ctrl_pipe_chain_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared definitions for the control-word pipeline chain:
//   - bit positions and widths of every field in the 14-bit control word
//     (ALU_OP[13:10], LOAD, MEM_WRITE, STORE_CC, B, BL, MEM_SIZE, MEM_E,
//     RF_E, AM[1:0])
//   - field-subset masks for the EX, MEM and WB register stages
//   - the per-stage update operation enum
//   - a saturating 16-bit increment used by the event counters
// ----------------------------------------------------------------------------
package ctrl_pipe_pkg;

    localparam int CTRL_WIDTH    = 14;

    localparam int ALU_OP_LSB    = 10;
    localparam int ALU_OP_WIDTH  = 4;
    localparam int LOAD_BIT      = 9;
    localparam int MEM_WRITE_BIT = 8;
    localparam int STORE_CC_BIT  = 7;
    localparam int B_BIT         = 6;
    localparam int BL_BIT        = 5;
    localparam int MEM_SIZE_BIT  = 4;
    localparam int MEM_E_BIT     = 3;
    localparam int RF_E_BIT      = 2;
    localparam int AM_LSB        = 0;
    localparam int AM_WIDTH      = 2;

    typedef logic [CTRL_WIDTH-1:0] ctrl_word_t;

    // One-hot / multi-bit field selectors built from the offsets above.
    localparam ctrl_word_t F_ALU_OP    = ctrl_word_t'(((1 << ALU_OP_WIDTH) - 1) << ALU_OP_LSB);
    localparam ctrl_word_t F_LOAD      = ctrl_word_t'(1 << LOAD_BIT);
    localparam ctrl_word_t F_MEM_WRITE = ctrl_word_t'(1 << MEM_WRITE_BIT);
    localparam ctrl_word_t F_STORE_CC  = ctrl_word_t'(1 << STORE_CC_BIT);
    localparam ctrl_word_t F_B         = ctrl_word_t'(1 << B_BIT);
    localparam ctrl_word_t F_BL        = ctrl_word_t'(1 << BL_BIT);
    localparam ctrl_word_t F_MEM_SIZE  = ctrl_word_t'(1 << MEM_SIZE_BIT);
    localparam ctrl_word_t F_MEM_E     = ctrl_word_t'(1 << MEM_E_BIT);
    localparam ctrl_word_t F_RF_E      = ctrl_word_t'(1 << RF_E_BIT);
    localparam ctrl_word_t F_AM        = ctrl_word_t'(((1 << AM_WIDTH) - 1) << AM_LSB);

    // EX consumes every field; MEM only needs memory and write-back
    // controls; WB only needs the register-file write controls.
    localparam ctrl_word_t MASK_ID_EX  = F_ALU_OP | F_LOAD | F_MEM_WRITE | F_STORE_CC | F_B
                                       | F_BL | F_MEM_SIZE | F_MEM_E | F_RF_E | F_AM;
    localparam ctrl_word_t MASK_EX_MEM = F_LOAD | F_MEM_WRITE | F_BL | F_MEM_SIZE | F_MEM_E | F_RF_E;
    localparam ctrl_word_t MASK_MEM_WB = F_LOAD | F_BL | F_RF_E;

    typedef enum logic [1:0] {
        STAGE_LOAD   = 2'd0,
        STAGE_HOLD   = 2'd1,
        STAGE_BUBBLE = 2'd2,
        STAGE_FLUSH  = 2'd3
    } stage_op_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
        return (en && (value != 16'hFFFF)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_chain_if
// Bundles the control-unit side and datapath side of the control pipeline.
//   master (control unit / hazard unit): drives in_ctrl, in_valid, nop_sel,
//          stall, flush; observes in_ready, stage_ctrl, stage_valid and the
//          two event counters.
//   slave  (ctrl_pipe_chain): the reverse directions.
// ----------------------------------------------------------------------------
interface ctrl_pipe_chain_if
    import ctrl_pipe_pkg::*;
#(
    parameter int WIDTH  = CTRL_WIDTH,
    parameter int STAGES = 4
);

    logic [WIDTH-1:0]        in_ctrl;
    logic                    in_valid;
    logic                    nop_sel;
    logic [STAGES-1:0]       stall;
    logic [STAGES-1:0]       flush;
    logic                    in_ready;
    logic [STAGES*WIDTH-1:0] stage_ctrl;
    logic [STAGES-1:0]       stage_valid;
    logic [15:0]             retired_count;
    logic [15:0]             bubble_count;

    modport master (
        output in_ctrl, in_valid, nop_sel, stall, flush,
        input  in_ready, stage_ctrl, stage_valid, retired_count, bubble_count
    );

    modport slave (
        input  in_ctrl, in_valid, nop_sel, stall, flush,
        output in_ready, stage_ctrl, stage_valid, retired_count, bubble_count
    );

endinterface

// File: rtl/ctrl_pipe_chain_stage.sv
// ----------------------------------------------------------------------------
// ctrl_stage_reg
// One pipeline register of the control chain: a WIDTH-bit control word plus
// a valid bit. Update priority at each rising edge:
//   reset > flush > hold > bubble > load.
// Flush, bubble and reset all load NOP_VALUE & MASK with valid cleared; a
// normal load captures i_ctrl & MASK with i_valid.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_flush      load a bubble this edge (overrides hold)
//   i_hold       keep current contents
//   i_bubble     upstream stage is frozen: insert a bubble instead of loading
//   i_ctrl       incoming control word (from the previous stage or input mux)
//   i_valid      valid bit accompanying i_ctrl
//   o_ctrl       registered control word
//   o_valid      registered valid bit
//   o_op         operation this stage performs at the coming edge
// ----------------------------------------------------------------------------
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int               WIDTH     = CTRL_WIDTH,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter logic [WIDTH-1:0] MASK      = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_hold,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_ctrl,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_ctrl,
    output logic             o_valid,
    output stage_op_t        o_op
);

    localparam logic [WIDTH-1:0] NOP_MASKED = NOP_VALUE & MASK;

    logic [WIDTH-1:0] r_ctrl;
    logic             r_valid;
    stage_op_t        w_op;

    // NOTE: the default is assigned first so every path through the block
    // drives w_op; a missing branch would otherwise infer a latch.
    always_comb begin
        w_op = STAGE_LOAD;
        if (i_flush) begin
            w_op = STAGE_FLUSH;
        end else if (i_hold) begin
            w_op = STAGE_HOLD;
        end else if (i_bubble) begin
            w_op = STAGE_BUBBLE;
        end
    end

    // NOTE: non-blocking assignments so every stage samples its neighbour's
    // pre-edge value; blocking here would let a word race through the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl  <= NOP_MASKED;
            r_valid <= 1'b0;
        end else begin
            unique case (w_op)
                STAGE_FLUSH, STAGE_BUBBLE: begin
                    r_ctrl  <= NOP_MASKED;
                    r_valid <= 1'b0;
                end
                STAGE_LOAD: begin
                    r_ctrl  <= i_ctrl & MASK;
                    r_valid <= i_valid;
                end
                STAGE_HOLD: begin
                    r_ctrl  <= r_ctrl;
                    r_valid <= r_valid;
                end
            endcase
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_valid = r_valid;
    assign o_op    = w_op;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_chain
// Chain of STAGES control-word registers from decode (stage 0 = ID/EX) to
// write-back (last stage = MEM/WB), with per-stage field masks, stall-driven
// bubble insertion, per-stage flush and valid tracking.
// Ports:
//   clk     clock
//   reset   synchronous, active-high
//   bus     ctrl_pipe_chain_if.slave:
//             in_ctrl/in_valid/nop_sel  word offered by the control unit
//             stall/flush               per-stage hazard controls
//             in_ready                  stage 0 accepts this edge (comb.)
//             stage_ctrl/stage_valid    registered word + valid per stage
//             retired_count             saturating count of valid words
//                                       entering the last stage
//             bubble_count              saturating count of stall bubbles
// ----------------------------------------------------------------------------
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int                      WIDTH      = CTRL_WIDTH,
    parameter int                      STAGES     = 4,
    parameter logic [WIDTH-1:0]        NOP_VALUE  = '0,
    parameter logic [STAGES*WIDTH-1:0] STAGE_MASK = '1
) (
    input  logic              clk,
    input  logic              reset,
    ctrl_pipe_chain_if.slave  bus
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_bubble_in;
    logic [STAGES-1:0] w_bubble_evt;
    logic [STAGES-1:0] w_src_valid;
    logic [STAGES-1:0] w_stage_valid;
    logic [WIDTH-1:0]  w_src_ctrl   [STAGES];
    logic [WIDTH-1:0]  w_stage_ctrl [STAGES];
    stage_op_t         w_stage_op   [STAGES];
    logic              w_retire;
    logic [15:0]       r_retired_count;
    logic [15:0]       r_bubble_count;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // A stall freezes its own stage and everything upstream of it.
        if (k == LAST) begin : g_hold_last
            assign w_hold[k] = bus.stall[k];
        end else begin : g_hold_mid
            assign w_hold[k] = bus.stall[k] | w_hold[k+1];
        end

        if (k == 0) begin : g_src_input
            assign w_src_ctrl[k]  = bus.nop_sel ? NOP_VALUE : bus.in_ctrl;
            assign w_src_valid[k] = ~bus.nop_sel & bus.in_valid;
            assign w_bubble_in[k] = 1'b0;
        end else begin : g_src_prev
            assign w_src_ctrl[k]  = w_stage_ctrl[k-1];
            assign w_src_valid[k] = w_stage_valid[k-1];
            // A frozen upstream stage leaves a gap below it. When that stage
            // is being flushed it does not keep its word, so the word moves on
            // instead of being replaced by a bubble.
            assign w_bubble_in[k] = w_hold[k-1] & ~bus.flush[k-1];
        end

        ctrl_stage_reg #(
            .WIDTH     (WIDTH),
            .NOP_VALUE (NOP_VALUE),
            .MASK      (STAGE_MASK[k*WIDTH +: WIDTH])
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .i_flush  (bus.flush[k]),
            .i_hold   (w_hold[k]),
            .i_bubble (w_bubble_in[k]),
            .i_ctrl   (w_src_ctrl[k]),
            .i_valid  (w_src_valid[k]),
            .o_ctrl   (w_stage_ctrl[k]),
            .o_valid  (w_stage_valid[k]),
            .o_op     (w_stage_op[k])
        );

        assign w_bubble_evt[k] = (w_stage_op[k] == STAGE_BUBBLE);
    end

    // hold is monotone towards stage 0, so at most one stage sits on the
    // frozen/moving boundary and at most one bubble is inserted per edge.
    assign w_retire = (w_stage_op[LAST] == STAGE_LOAD) && w_src_valid[LAST];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_count <= 16'd0;
            r_bubble_count  <= 16'd0;
        end else begin
            r_retired_count <= sat_inc16(r_retired_count, w_retire);
            r_bubble_count  <= sat_inc16(r_bubble_count, |w_bubble_evt);
        end
    end

    always_comb begin
        bus.stage_ctrl = '0;
        for (int k = 0; k < STAGES; k++) begin
            bus.stage_ctrl[k*WIDTH +: WIDTH] = w_stage_ctrl[k];
        end
    end

    assign bus.stage_valid   = w_stage_valid;
    assign bus.in_ready      = ~w_hold[0];
    assign bus.retired_count = r_retired_count;
    assign bus.bubble_count  = r_bubble_count;

endmodule

// File: doc/ctrl_pipe_chain.md
# ctrl_pipe_chain

Parametrised chain of pipeline registers carrying the decoded control word from decode through write-back. It generalises the fixed ID/EX, EX/MEM and MEM/WB control registers into one block with configurable word width and stage count. It adds per-stage field masks, stall-driven bubble insertion, per-stage flush and valid tracking. It sits between the control unit / NOP-select mux and the datapath stage logic.

## Interface
- WIDTH, 14, control word width. Default field order: ALU_OP[3:0], LOAD, MEM_WRITE, STORE_CC, B, BL, MEM_SIZE, MEM_E, RF_E, AM[1:0].
- STAGES, 4, number of register stages. Stage 0 = ID/EX; last stage = MEM/WB.
- NOP_VALUE, 0, control word used for bubbles, flushes and reset.
- STAGE_MASK, all ones, flattened [STAGES*WIDTH-1:0]. Bits cleared in slice k are forced to 0 on entry to stage k.
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock, reset synchronous and active-high as decided.
- in_ctrl  in  WIDTH  control word from the control unit.
- in_valid  in  1  in_ctrl holds a real instruction.
- nop_sel  in  1  1 = replace the input with a bubble (NOP_VALUE, valid 0).
- stall  in  STAGES  stall[k] = stage k must hold its contents.
- flush  in  STAGES  flush[k] = stage k loads a bubble.
- in_ready  out  1  stage 0 will accept in_ctrl this edge; equals ~hold[0].
- stage_ctrl  out  STAGES*WIDTH  registered control word per stage; slice k = [k*WIDTH +: WIDTH].
- stage_valid  out  STAGES  valid bit per stage.
- retired_count  out  16  saturating count of valid words loaded into the last stage.
- bubble_count  out  16  saturating count of stall-induced bubbles.

## Operation
- hold[k] = OR of stall[j] for j ≥ k. A stall at any stage freezes that stage and every stage upstream of it.
- Per-stage update at each edge, highest priority first:
  - reset: ctrl = NOP_VALUE & mask, valid = 0, both counters = 0.
  - flush[k]: ctrl = NOP_VALUE & mask, valid = 0. Flush overrides hold.
  - hold[k]: contents unchanged.
  - k > 0 and hold[k-1]: bubble loaded (NOP_VALUE & mask, valid 0); bubble_count += 1.
  - otherwise: ctrl = stage k-1 contents & mask_k, valid = stage k-1 valid. For stage 0 the source is the input mux.
- Input mux: nop_sel = 1 → NOP_VALUE with valid 0; otherwise in_ctrl with in_valid.
- While hold[0] = 1 the input is ignored. Upstream must hold PC and IF/ID using in_ready.
- retired_count increments when the last stage loads a word with valid 1 via the normal path.
- Both counters saturate at 16'hFFFF and never wrap.
- Flushed and bubble words keep NOP_VALUE bits even where the mask allows other values. Datapath consumers must gate on stage_valid.

## Timing
- Latency: a word presented with in_ready = 1 at edge n appears in stage k after edge n+k. Without stalls it reaches the last stage after STAGES edges.
- All outputs are registered. in_ready is combinational from stall.
- Simultaneous stall[k] and flush[k]: the stage flushes and upstream stages still hold.
- Simultaneous stall[k] and flush[k+1]: stage k+1 is flushed; no bubble count is added.
- Reset asserted mid-stall or mid-flush clears everything at that edge. The first capture happens at the first edge with reset = 0.
- stall = 0 and flush = 0 for one cycle: every stage shifts by one. No word is duplicated or dropped.

## Structure
- Package ctrl_pipe_pkg holds:
  - field offset and width constants for the control word (ALU_OP_LSB, LOAD_BIT, …, AM_LSB);
  - default WIDTH = 14;
  - per-stage mask constants matching the EX, MEM and WB field subsets.
- Sub-module ctrl_stage_reg implements one stage: WIDTH-bit register plus valid bit, with load/hold/bubble/flush priority and mask.
- The top level generates STAGES instances, the hold OR-chain, the input mux and both counters.

## Test plan
- Reset, then feed 0x0001, 0x0002, 0x0003 with in_valid = 1 → stage 3 shows 0x0001 after edge 4, 0x0002 after edge 5, 0x0003 after edge 6; retired_count = 3.
- stall[1] = 1 for 2 cycles with the pipe full → stages 0–1 frozen, in_ready = 0; stage 2 receives 2 bubbles (ctrl 0, valid 0); bubble_count = 2; no word is lost after release.
- flush[0] and stall[0] together with stage 0 = 0x1234 → stage 0 becomes 0x0000 with valid 0; stage 1 receives 0x1234.
- STAGE_MASK slice 2 = 0x0FF0, input 0x3FFF → stage 2 shows 0x0FF0 and stage 3 shows 0x0FF0 (its own mask is all ones).
- nop_sel = 1 with in_ctrl = 0x2AAA, in_valid = 1 → stage 0 = NOP_VALUE with valid 0; retired_count unchanged 4 edges later.
- Preload retired_count to 0xFFFE via forced stimulus, then retire 3 words → reads 0xFFFF. Then assert reset mid-stall → all outputs 0 at the next edge.
